// File: rtl/atan_arg_div.sv
`default_nettype none
// ============================================================================
// Module   : atan_arg_div
// Brief    : First-octant fold of an I/Q sample plus iterative min/max
//            restoring divider producing the atan LUT index and octant tag.
//            Build option: ATAN_ARG_ROUND_EN (one extra quotient bit, rounding).
// Revision : 1.0
// ============================================================================
module atan_arg_div #(
  parameter int IQ_WIDTH  = 16,
  parameter int ARG_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [2*IQ_WIDTH-1:0]   s_axis_in_tdata,
  input  logic                    s_axis_in_tvalid,
  output logic                    s_axis_in_tready,
  output logic [ARG_WIDTH-1:0]    m_axis_out_tdata,
  output logic [2:0]              m_axis_out_tuser,
  output logic                    m_axis_out_tvalid,
  input  logic                    m_axis_out_tready
);

`ifdef ATAN_ARG_ROUND_EN
  localparam int ITERS = ARG_WIDTH + 1;
`else
  localparam int ITERS = ARG_WIDTH;
`endif
  localparam int CNT_W = $clog2(ITERS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [IQ_WIDTH-1:0]    den_q, den_d;
  logic [IQ_WIDTH:0]      rem_q, rem_d;
  logic [ITERS-1:0]       quo_q, quo_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sat_q, sat_d;
  logic                   zero_q, zero_d;
  logic [2:0]             tuser_q, tuser_d;
  logic [ARG_WIDTH-1:0]   tdata_q, tdata_d;

  logic [IQ_WIDTH-1:0]    in_i, in_q, mag_i, mag_q, num_in, den_in;
  logic                   swap_in;
  logic [IQ_WIDTH:0]      rem_shift, rem_diff;
  logic                   qbit;
  logic [ITERS-1:0]       quo_next;
  logic [ARG_WIDTH-1:0]   result;
`ifdef ATAN_ARG_ROUND_EN
  logic [ARG_WIDTH:0]     rnd_val;
`endif

  always_comb begin
    in_i    = s_axis_in_tdata[IQ_WIDTH-1:0];
    in_q    = s_axis_in_tdata[2*IQ_WIDTH-1:IQ_WIDTH];
    // Unsigned negation wraps -2^(W-1) onto its exact magnitude.
    mag_i   = in_i[IQ_WIDTH-1] ? (~in_i + 1'b1) : in_i;
    mag_q   = in_q[IQ_WIDTH-1] ? (~in_q + 1'b1) : in_q;
    swap_in = (mag_q > mag_i);
    num_in  = swap_in ? mag_i : mag_q;
    den_in  = swap_in ? mag_q : mag_i;

    rem_shift = rem_q << 1;
    rem_diff  = rem_shift - {1'b0, den_q};
    qbit      = (rem_shift >= {1'b0, den_q});
    quo_next  = {quo_q[ITERS-2:0], qbit};

    // num==den is caught at load time (sat), so the divider only ever sees num<den.
`ifdef ATAN_ARG_ROUND_EN
    rnd_val = {1'b0, quo_next[ITERS-1:1]} + {{ARG_WIDTH{1'b0}}, quo_next[0]};
    if (zero_q)
      result = '0;
    else if (sat_q || rnd_val[ARG_WIDTH])
      result = '1;
    else
      result = rnd_val[ARG_WIDTH-1:0];
`else
    if (zero_q)
      result = '0;
    else if (sat_q)
      result = '1;
    else
      result = quo_next;
`endif
  end

  always_comb begin
    state_d = state_q;
    den_d   = den_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    zero_d  = zero_q;
    tuser_d = tuser_q;
    tdata_d = tdata_q;

    case (state_q)
      IDLE: begin
        if (s_axis_in_tvalid) begin
          den_d   = den_in;
          rem_d   = (num_in == den_in) ? '0 : {1'b0, num_in};
          quo_d   = '0;
          cnt_d   = '0;
          sat_d   = (num_in == den_in) && (den_in != '0);
          zero_d  = (den_in == '0);
          tuser_d = {swap_in, in_i[IQ_WIDTH-1], in_q[IQ_WIDTH-1]};
          state_d = DIV;
        end
      end
      DIV: begin
        rem_d = qbit ? rem_diff : rem_shift;
        quo_d = quo_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          tdata_d = result;
          state_d = DONE;
        end
      end
      DONE: begin
        if (m_axis_out_tready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      den_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      zero_q  <= 1'b0;
      tuser_q <= '0;
      tdata_q <= '0;
    end else begin
      state_q <= state_d;
      den_q   <= den_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      zero_q  <= zero_d;
      tuser_q <= tuser_d;
      tdata_q <= tdata_d;
    end
  end

  assign s_axis_in_tready  = (state_q == IDLE);
  assign m_axis_out_tvalid = (state_q == DONE);
  assign m_axis_out_tdata  = tdata_q;
  assign m_axis_out_tuser  = tuser_q;

endmodule
`default_nettype wire

// File: tb/tb_atan_arg_div.sv
`default_nettype none
// Bench for atan_arg_div: directed octant/saturation/backpressure/reset cases
// followed by a throttled random stream scored against an arithmetic model.
module tb_atan_arg_div;
  localparam int IQ  = 16;
  localparam int ARG = 16;
`ifdef ATAN_ARG_ROUND_EN
  localparam int ITERS = ARG + 1;
`else
  localparam int ITERS = ARG;
`endif
  // Accept is observed on the negedge before its clock edge, so the first
  // negedge showing tvalid comes ITERS+1 sample points later.
  localparam int LAT_NEG = ITERS + 1;

  typedef struct {
    logic [ARG-1:0] d;
    logic [2:0]     u;
    int             c;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [2*IQ-1:0]   s_tdata = '0;
  logic              s_tvalid = 1'b0;
  logic              s_tready;
  logic [ARG-1:0]    m_tdata;
  logic [2:0]        m_tuser;
  logic              m_tvalid;
  logic              m_tready = 1'b1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int accepted = 0;
  int emitted = 0;
  int discarded = 0;
  logic prev_valid = 1'b0;
  exp_t exp_q[$];

  atan_arg_div #(.IQ_WIDTH(IQ), .ARG_WIDTH(ARG)) dut (
    .clk_i             (clk),
    .reset_i           (rst),
    .s_axis_in_tdata   (s_tdata),
    .s_axis_in_tvalid  (s_tvalid),
    .s_axis_in_tready  (s_tready),
    .m_axis_out_tdata  (m_tdata),
    .m_axis_out_tuser  (m_tuser),
    .m_axis_out_tvalid (m_tvalid),
    .m_axis_out_tready (m_tready)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2*IQ-1:0] data, input int c);
    exp_t   e;
    longint li, lq, mi, mq, num, den, a, maxv;
    logic   sw;
    li   = longint'($signed(data[IQ-1:0]));
    lq   = longint'($signed(data[2*IQ-1:IQ]));
    mi   = (li < 0) ? -li : li;
    mq   = (lq < 0) ? -lq : lq;
    sw   = (mq > mi);
    num  = sw ? mi : mq;
    den  = sw ? mq : mi;
    maxv = (longint'(1) << ARG) - 1;
    if (den == 0)
      a = 0;
    else begin
`ifdef ATAN_ARG_ROUND_EN
      a = (num * (longint'(1) << (ARG + 1)) + den) / (2 * den);
`else
      a = (num * (longint'(1) << ARG)) / den;
`endif
    end
    if (a > maxv) a = maxv;
    e.d = a[ARG-1:0];
    e.u = {sw, li < 0, lq < 0};
    e.c = c;
    return e;
  endfunction

  // Scoreboard / compare process, sampled away from the active edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      if (exp_q.size() != 0) discarded = discarded + exp_q.size();
      exp_q.delete();
      prev_valid = 1'b0;
    end else begin
      checks = checks + 1;
      if (s_tready !== (exp_q.size() == 0)) begin
        failures = failures + 1;
        $display("FAIL s_tready: got %b want %b at cycle %0d", s_tready, exp_q.size() == 0, cyc);
      end
      if (m_tvalid) begin
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          failures = failures + 1;
          $display("FAIL spurious_beat: tvalid=1 with nothing in flight, tdata=%0d at cycle %0d", m_tdata, cyc);
        end else begin
          if (m_tdata !== exp_q[0].d || m_tuser !== exp_q[0].u) begin
            failures = failures + 1;
            $display("FAIL result: got tdata=%0d tuser=%b want tdata=%0d tuser=%b at cycle %0d",
                     m_tdata, m_tuser, exp_q[0].d, exp_q[0].u, cyc);
          end
          if (!prev_valid) begin
            checks = checks + 1;
            if (cyc - exp_q[0].c != LAT_NEG) begin
              failures = failures + 1;
              $display("FAIL latency: got %0d want %0d", cyc - exp_q[0].c, LAT_NEG);
            end
          end
          if (m_tready) begin
            void'(exp_q.pop_front());
            emitted = emitted + 1;
          end
        end
      end
      if (s_tvalid && s_tready) begin
        exp_q.push_back(model(s_tdata, cyc));
        accepted = accepted + 1;
      end
      prev_valid = m_tvalid;
    end
  end

  task automatic check_val(input string name, input int got, input int want);
    checks = checks + 1;
    if (got != want) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Presents one sample, waits for it to be accepted (bounded).
  task automatic send(input logic signed [IQ-1:0] i, input logic signed [IQ-1:0] q,
                      input logic rand_ready);
    logic acc;
    acc = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = {q, i};
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk); #1;
      if (rand_ready) m_tready = ($urandom_range(0, 3) != 0);
      if (acc) break;
    end
    s_tvalid = 1'b0;
    if (!acc) begin
      failures = failures + 1;
      $display("FAIL accept_timeout: got no s_tready want s_tready=1 within 500 cycles");
    end
  endtask

  task automatic run_directed(input string name, input logic signed [IQ-1:0] i,
                              input logic signed [IQ-1:0] q, input int ed,
                              input int eu, input int hold);
    logic got;
    @(posedge clk); #1;
    m_tready = (hold == 0);
    send(i, q, 1'b0);
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (m_tvalid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      failures = failures + 1;
      $display("FAIL %s_timeout: got no m_tvalid want m_tvalid=1", name);
    end else begin
      check_val({name, "_tdata"}, int'(m_tdata), ed);
      check_val({name, "_tuser"}, int'(m_tuser), eu);
      if (hold > 0) begin
        repeat (hold) @(negedge clk);
        check_val({name, "_held_tdata"}, int'(m_tdata), ed);
        check_val({name, "_held_s_tready"}, int'(s_tready), 0);
        @(posedge clk); #1;
        m_tready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check_val({name, "_s_tready_after"}, int'(s_tready), 1);
        check_val({name, "_tvalid_after"}, int'(m_tvalid), 0);
      end
    end
  endtask

  initial begin
    logic signed [IQ-1:0] ri, rq;
    int sel;
    repeat (3) @(negedge clk);
    check_val("reset_s_tready", int'(s_tready), 1);
    check_val("reset_m_tvalid", int'(m_tvalid), 0);
    check_val("reset_m_tdata", int'(m_tdata), 0);
    check_val("reset_m_tuser", int'(m_tuser), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_directed("basic", 16'sd1000, 16'sd500, 32768, 3'b000, 0);
    run_directed("swapped", -16'sd300, 16'sd600, 32768, 3'b110, 0);
    run_directed("saturate", -16'sd32768, -16'sd32768, 65535, 3'b011, 0);
    run_directed("zero", 16'sd0, 16'sd0, 0, 3'b000, 0);
    run_directed("backpressure", 16'sd1000, -16'sd500, 32768, 3'b001, 10);

    // Abort a division in flight; nothing may come out of it.
    @(posedge clk); #1;
    m_tready = 1'b1;
    send(16'sd1234, -16'sd77, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < ITERS + 4; k++) begin
      @(negedge clk);
      check_val("abort_no_beat", int'(m_tvalid), 0);
    end
    check_val("abort_s_tready", int'(s_tready), 1);
`ifdef ATAN_ARG_ROUND_EN
    run_directed("after_reset", 16'sd3, 16'sd2, 43691, 3'b000, 0);
`else
    run_directed("after_reset", 16'sd3, 16'sd2, 43690, 3'b000, 0);
`endif

    for (int n = 0; n < 1000; n++) begin
      ri  = IQ'($urandom);
      rq  = IQ'($urandom);
      sel = $urandom_range(0, 7);
      case (sel)
        0: ri = -16'sd32768;
        1: begin ri = -16'sd32768; rq = -16'sd32768; end
        2: begin ri = '0; rq = '0; end
        3: rq = ri;
        4: rq = -ri;
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        m_tready = ($urandom_range(0, 3) != 0);
      end
      send(ri, rq, 1'b1);
    end

    m_tready = 1'b1;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    check_val("drain_empty", exp_q.size(), 0);
    check_val("beats_conserved", emitted + discarded, accepted);
    check_val("discarded_count", discarded, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    failures = failures + 1;
    $display("FAIL watchdog: got no completion want finish within time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/atan_arg_div.md
# atan_arg_div

- Sequential front end for the arctangent LUT.
- Accepts one complex I/Q sample over a valid/ready handshake and folds it into the first octant: absolute values, with the larger magnitude as denominator.
- Computes the unsigned ratio min/max with an iterative restoring divider. The resulting ARG_WIDTH-bit code indexes the atan LUT directly.
- Emits a 3-bit octant tag alongside the code, which the downstream unfold stage uses to rebuild the full-circle angle.

## Interface
- IQ_WIDTH, 16, width of each signed I and Q component
- ARG_WIDTH, 16, width of the unsigned ratio code (must equal the LUT's INPUT_WIDTH)
- clk_i  input  1  sole clock
- reset_i  input  1  asynchronous, active-high reset
- s_axis_in_tdata  input  2*IQ_WIDTH  {Q, I}, two's complement, I in low half
- s_axis_in_tvalid  input  1  input sample valid
- s_axis_in_tready  output  1  block can accept a sample
- m_axis_out_tdata  output  ARG_WIDTH  ratio code, 0 ↔ 0.0, 2^ARG_WIDTH−1 ↔ 1.0
- m_axis_out_tuser  output  3  octant tag {swap, sign_i, sign_q}
- m_axis_out_tvalid  output  1  result valid
- m_axis_out_tready  input  1  downstream accepts result

## Operation
- FSM states: IDLE, DIV, DONE. Reset enters IDLE.
- IDLE
  - s_axis_in_tready=1.
  - On s_tvalid&s_tready, register the following and go to DIV with iteration counter = 0:
    - mag_i=|I| and mag_q=|Q|, each IQ_WIDTH-bit unsigned, so |−2^(IQ_WIDTH−1)| = 2^(IQ_WIDTH−1) exactly.
    - sign_i=I[msb] and sign_q=Q[msb].
    - swap=(mag_q>mag_i), strict compare.
    - num=swap?mag_i:mag_q and den=swap?mag_q:mag_i.
- DIV
  - s_tready=0.
  - Each cycle produces one quotient bit, MSB first, via restoring division of num·2^ARG_WIDTH by den.
  - The remainder register is IQ_WIDTH+1 bits wide.
  - After ARG_WIDTH iterations, go to DONE.
- DONE
  - m_tvalid=1. tdata and tuser are held stable until m_tready.
  - On m_tvalid&m_tready, go to IDLE.
- Result: arg = min(floor(num·2^ARG_WIDTH/den), 2^ARG_WIDTH−1).
  - The saturation applies only when num==den (quotient would be 2^ARG_WIDTH).
- den==0 (I=Q=0): arg=0 and tuser=3'b000. The full iteration count still runs, giving identical latency.
- No input is accepted while DIV or DONE is active. The block never has more than one sample in flight.

## Timing
- Reset values:
  - s_axis_in_tready=1 (IDLE).
  - m_axis_out_tvalid=0.
  - m_axis_out_tdata=0.
  - m_axis_out_tuser=0.
- Latency: if the input handshake is at clock edge N, m_tvalid rises after edge N+ARG_WIDTH.
- Throughput: one sample per ARG_WIDTH+2 cycles with m_tready held high. This includes one IDLE cycle after the output handshake.
- Backpressure: m_tdata and m_tuser must not change while m_tvalid=1 and m_tready=0.
- reset_i during DIV or DONE:
  - Aborts the operation immediately and returns to IDLE.
  - m_tvalid drops asynchronously.
  - The in-flight sample is discarded and never emitted.
- s_tvalid is ignored while reset_i=1.

## Configuration
- ATAN_ARG_ROUND_EN
  - Defined: one extra quotient bit is computed (ARG_WIDTH+1 iterations) and arg = round-half-up of the ratio, saturated to 2^ARG_WIDTH−1. Latency and throughput each grow by one cycle.
  - Undefined: truncating behaviour as specified above.

## Test plan
- Basic quadrant, defaults: I=1000, Q=500 → tdata=32768, tuser=000, tvalid exactly 16 cycles after accept.
- Swapped octant: I=−300, Q=600 → tdata=32768, tuser=110.
- Saturation and most-negative input: I=Q=−32768 → tdata=65535, tuser=011. Also check I=Q=0 → tdata=0, tuser=000 with the same latency.
- Backpressure: hold m_tready=0 for 10 cycles after tvalid.
  - Required: tdata and tuser stable, s_tready=0 throughout.
  - Then release m_tready: one transfer, and s_tready returns to 1 the next cycle.
- Reset mid-DIV:
  - Pulse reset_i at iteration 5; required: no output beat appears, s_tready=1.
  - A new sample I=3, Q=2 then gives tdata=43690 (43691 with ATAN_ARG_ROUND_EN).
- Random stream of 1000 samples with random tvalid/tready throttling, compared against the reference model floor/round formula:
  - Required: tdata and tuser match the model for every sample.
  - Required: no beats dropped or duplicated.
